// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped instruction cache between fetch PC and decoder
// Optional flush port and valid-clear behaviour enabled by ICACHE_FLUSH_EN.
module inst_cache #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
`ifdef ICACHE_FLUSH_EN
  input  logic              flush,
`endif
  output logic              sta_enable,
  output logic              dec_enable,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [INST_W-1:0] mem_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  localparam int TAG_LSB = 2 + WORD_BITS + INDEX_BITS;
  localparam int TAG_W = ADDR_W - TAG_LSB;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic                   dec_enable_q, dec_enable_d;
  logic [INST_W-1:0]      dec_inst_q, dec_inst_d;
  logic [ADDR_W-1:0]      dec_addr_q, dec_addr_d;

  logic [INST_W-1:0]      data_q [LINES*WORDS];
  logic [TAG_W-1:0]       tag_q [LINES];
  logic                   data_we, tag_we;
  logic                   flush_w;

`ifdef ICACHE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic [WORD_BITS-1:0]  in_word, rq_word;
  logic [INDEX_BITS-1:0] in_index, rq_index;
  logic [TAG_W-1:0]      in_tag, rq_tag;
  logic                  hit;

  assign in_word  = addr[2 +: WORD_BITS];
  assign in_index = addr[2+WORD_BITS +: INDEX_BITS];
  assign in_tag   = addr[ADDR_W-1:TAG_LSB];
  assign rq_word  = req_addr_q[2 +: WORD_BITS];
  assign rq_index = req_addr_q[2+WORD_BITS +: INDEX_BITS];
  assign rq_tag   = req_addr_q[ADDR_W-1:TAG_LSB];
  assign hit      = valid_q[in_index] && (tag_q[in_index] == in_tag);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_addr_d   = req_addr_q;
    valid_d      = valid_q;
    dec_enable_d = 1'b0;
    dec_inst_d   = dec_inst_q;
    dec_addr_d   = dec_addr_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce && !stall) begin
          req_addr_d = addr;
          if (hit) begin
            dec_enable_d = 1'b1;
            dec_inst_d   = data_q[{in_index, in_word}];
            dec_addr_d   = addr;
          end else begin
            state_d = REFILL;
            cnt_d   = '0;
          end
        end
      end
      REFILL: begin
        if (mem_ready) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // Line becomes valid only once its last word has landed.
          if (cnt_q == {WORD_BITS{1'b1}}) begin
            valid_d[rq_index] = 1'b1;
            tag_we            = 1'b1;
            state_d           = RESP;
          end
        end
      end
      RESP: begin
        if (!stall) begin
          dec_enable_d = 1'b1;
          dec_inst_d   = data_q[{rq_index, rq_word}];
          dec_addr_d   = req_addr_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_w) begin
      valid_d      = '0;
      state_d      = IDLE;
      dec_enable_d = 1'b0;
      data_we      = 1'b0;
      tag_we       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_addr_q   <= '0;
      valid_q      <= '0;
      dec_enable_q <= 1'b0;
      dec_inst_q   <= '0;
      dec_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_addr_q   <= req_addr_d;
      valid_q      <= valid_d;
      dec_enable_q <= dec_enable_d;
      dec_inst_q   <= dec_inst_d;
      dec_addr_q   <= dec_addr_d;
    end
  end

  // Data and tag storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (data_we) data_q[{rq_index, cnt_q}] <= mem_data;
    if (tag_we)  tag_q[rq_index] <= rq_tag;
  end

  assign sta_enable = (state_q == IDLE);
  assign dec_enable = dec_enable_q & ~flush_w;
  assign dec_inst   = dec_inst_q;
  assign dec_addr   = dec_addr_q;
  assign mem_req    = (state_q == REFILL) & ~flush_w;
  assign mem_addr   = mem_req ? {req_addr_q[ADDR_W-1:2+WORD_BITS], cnt_q, 2'b00} : '0;

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache against a line-level cache model
// Flush scenario runs only when ICACHE_FLUSH_EN is defined.
module tb_inst_cache;

  logic        clk, rst, ce, stall;
  logic [31:0] addr;
  logic        sta_enable, dec_enable, mem_req, mem_ready;
  logic [31:0] dec_inst, dec_addr, mem_addr, mem_data;
`ifdef ICACHE_FLUSH_EN
  logic        flush;
`endif

  int checks = 0;
  int errors = 0;

  bit          mvalid [16];
  logic [23:0] mtag   [16];

  logic [31:0] hs [$];
  int          req_cycles;
  bit          rand_wait;

  inst_cache dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .stall(stall),
`ifdef ICACHE_FLUSH_EN
    .flush(flush),
`endif
    .sta_enable(sta_enable), .dec_enable(dec_enable), .dec_inst(dec_inst),
    .dec_addr(dec_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Memory: each word holds its own word-aligned byte address.
  initial begin
    mem_ready = 1'b0;
    mem_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        req_cycles++;
        mem_ready = !rand_wait || ($urandom_range(0, 2) == 0);
        mem_data  = mem_ready ? mem_addr : 32'hDEAD_BEEF;
        if (mem_ready) hs.push_back(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_data  = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    mvalid[a[7:4]] = 1'b1;
    mtag[a[7:4]]   = a[31:8];
  endtask

  task automatic chk_line(input string tag, input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    chk({tag, "_nreq"}, hs.size(), 4);
    if (hs.size() == 4)
      for (int i = 0; i < 4; i++) chk({tag, "_maddr"}, hs[i], base + 4 * i);
  endtask

  task automatic do_fetch(input logic [31:0] a, input string tag);
    bit exp_hit, got;
    int lat;
    exp_hit = mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
    @(negedge clk);
    chk({tag, "_sta"}, sta_enable, 1);
    hs.delete();
    req_cycles = 0;
    ce = 1'b1;
    addr = a;
    @(negedge clk);
    ce = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 300) begin
      if (dec_enable === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_pulse"}, got, 1);
    chk({tag, "_inst"}, dec_inst, {a[31:2], 2'b00});
    chk({tag, "_daddr"}, dec_addr, a);
    if (exp_hit) begin
      chk({tag, "_hitlat"}, lat, 1);
      chk({tag, "_hitreq"}, req_cycles, 0);
    end else begin
      chk_line(tag, a);
      chk({tag, "_misslat"}, lat, req_cycles + 2);
      if (!rand_wait) chk({tag, "_zwlat"}, lat, 6);
      model_fill(a);
    end
  endtask

  initial begin
    logic [31:0] ra;
    int n;
    rst = 1'b1; ce = 1'b0; stall = 1'b0; addr = 32'h0; rand_wait = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    model_clear();

    @(negedge clk);
    chk("rst_sta", sta_enable, 1);
    chk("rst_den", dec_enable, 0);
    chk("rst_dinst", dec_inst, 0);
    chk("rst_daddr", dec_addr, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_maddr", mem_addr, 0);
    rst = 1'b0;

    do_fetch(32'h0000_0104, "t1");

    @(negedge clk);
    ce = 1'b1;
    addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_den", dec_enable, 1);
      chk("t2_inst", dec_inst, 32'h100 + 4 * i);
      chk("t2_sta", sta_enable, 1);
      chk("t2_mreq", mem_req, 0);
      if (i < 3) addr = 32'h104 + 4 * i;
      else ce = 1'b0;
    end

    do_fetch(32'h0000_0500, "t3a");
    do_fetch(32'h0000_0100, "t3b");

    @(negedge clk);
    hs.delete();
    req_cycles = 0;
    ce = 1'b1;
    addr = 32'h200;
    @(negedge clk);
    ce = 1'b0;
    stall = 1'b1;
    n = 0;
    while (mem_req === 1'b1 && n < 100) begin
      chk("t4_nopulse_refill", dec_enable, 0);
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("t4_nopulse_resp", dec_enable, 0);
      chk("t4_sta", sta_enable, 0);
      @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t4_pulse", dec_enable, 1);
    chk("t4_inst", dec_inst, 32'h200);
    chk("t4_daddr", dec_addr, 32'h200);
    @(negedge clk);
    chk("t4_single", dec_enable, 0);
    chk_line("t4", 32'h200);
    model_fill(32'h200);

    @(negedge clk);
    ce = 1'b1;
    addr = 32'h300;
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_req_pre", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("t5_req_async", mem_req, 0);
    chk("t5_maddr", mem_addr, 0);
    chk("t5_sta", sta_enable, 1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    do_fetch(32'h0000_0300, "t5");
    do_fetch(32'h0000_0104, "t5b");

`ifdef ICACHE_FLUSH_EN
    do_fetch(32'h0000_0100, "t6a");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    do_fetch(32'h0000_0100, "t6b");
    @(negedge clk);
    ce = 1'b1;
    addr = 32'h140;
    @(negedge clk);
    ce = 1'b0;
    chk("t6_req_pre", mem_req, 1);
    flush = 1'b1;
    #1;
    chk("t6_req_flush", mem_req, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("t6_sta", sta_enable, 1);
    chk("t6_mreq", mem_req, 0);
    chk("t6_den", dec_enable, 0);
    model_clear();
    do_fetch(32'h0000_0140, "t6c");
`endif

    rand_wait = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h8000_0000;
      do_fetch(ra, "rnd");
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
